dbm_seq: RTL

DBM_SEQ -- requirements
Module: dbm_seq

---
 rtl/dbm_seq_pkg.sv | 10 +
 rtl/dbm_seq_timer.sv | 18 +
 rtl/dbm_seq.sv | 57 +++++
 3 files changed

// File: rtl/dbm_seq_pkg.sv
// dbm_seq_pkg: shared state, DBM select and CPU phase encodings for the memory-read sequencer.
package dbm_seq_pkg;
  typedef enum logic {RUN, WAIT} state_t;
  typedef enum logic [2:0] {
    DBM_SCAD, DBM_BYTES, DBM_EXP, DBM_DP, DBM_VMA, DBM_PF, DBM_MEM, DBM_NUM
  } dbm_sel_t;
  typedef enum logic [1:4] {
    PH_STALL = 4'b0000, T1 = 4'b1000, T2 = 4'b0100, T3 = 4'b0010, T4 = 4'b0001
  } phase_t;
endpackage

// File: rtl/dbm_seq_timer.sv
// dbm_seq_timer: 8-bit saturating memory-wait counter that flags when the wait limit is reached.
module dbm_seq_timer #(
  parameter int unsigned TIMEOUT = 127
) (
  input  logic memCLK,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam logic [7:0] LIMIT = 8'(TIMEOUT);
  logic [7:0] cnt;
  always_ff @(posedge memCLK or posedge rst)
    if (rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable && cnt != 8'hff) cnt <= cnt + 8'd1;
  assign expired = enable && cnt >= LIMIT;
endmodule

// File: rtl/dbm_seq.sv
// dbm_seq: CPU phase generator that stalls at T2 for memory reads and resumes at T3 with latched data.
module dbm_seq
  import dbm_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = 127,
  parameter logic [2:0]  MEMSEL  = DBM_MEM
) (
  input  logic        memCLK,
  input  logic        rst,
  input  logic [2:0]  dbmSEL,
  input  logic        memRD,
  input  logic        busACK,
  input  logic [0:35] busDATA,
  output logic [1:4]  clkPHS,
  output logic        busREQ,
  output logic [0:35] cpuDATAI,
  output logic        memWAIT,
  output logic        nxmFLAG
);
  state_t state;
  logic start, expired;
  assign start = state == RUN && clkPHS == T2 && memRD && dbmSEL == MEMSEL;
  dbm_seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .memCLK (memCLK),
    .rst    (rst),
    .clear  (start),
    .enable (state == WAIT),
    .expired(expired)
  );
  // busACK takes priority over timeout, so a late-but-valid reply never raises NXM
  always_ff @(posedge memCLK or posedge rst)
    if (rst) begin
      state    <= RUN;
      clkPHS   <= T1;
      busREQ   <= 1'b0;
      memWAIT  <= 1'b0;
      nxmFLAG  <= 1'b0;
      cpuDATAI <= '0;
    end else begin
      nxmFLAG <= 1'b0;
      if (state == RUN) begin
        if (start) begin
          state   <= WAIT;
          clkPHS  <= PH_STALL;
          busREQ  <= 1'b1;
          memWAIT <= 1'b1;
        end else clkPHS <= {clkPHS[4], clkPHS[1:3]};
      end else if (busACK || expired) begin
        state    <= RUN;
        clkPHS   <= T3;
        busREQ   <= 1'b0;
        memWAIT  <= 1'b0;
        cpuDATAI <= busACK ? busDATA : '1;
        nxmFLAG  <= !busACK;
      end
    end
endmodule
